// File: rtl/seq_det_pkg.sv
// Shared defaults and width helper for the sequence pattern detector.
package seq_det_pkg;

    localparam int DEFAULT_DATA_W  = 4;
    localparam int DEFAULT_SEQ_LEN = 4;

    // Width needed to hold a fill count in the range 0..seq_len.
    function automatic int fill_w(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    localparam int DEFAULT_FILL_W = fill_w(DEFAULT_SEQ_LEN);

endpackage

// File: rtl/sym_window.sv
// DATA_W x (SEQ_LEN-1) symbol history with a saturating fill counter.
module sym_window
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter int FILL_W  = fill_w(SEQ_LEN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          shift,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             data_in,
    output logic [(SEQ_LEN-1)*DATA_W-1:0] window,
    output logic [FILL_W-1:0]             fill
);

    localparam int WIN_W = (SEQ_LEN - 1) * DATA_W;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

    logic [WIN_W-1:0] win_next;

    generate
        if (SEQ_LEN > 2) begin : g_shift
            assign win_next = {window[WIN_W-DATA_W-1:0], data_in};
        end else begin : g_single
            assign win_next = data_in;
        end
    endgenerate

    // Flush only zeroes fill; stale window contents are masked by fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window <= '0;
            fill   <= '0;
        end else begin
            if (shift) begin
                window <= win_next;
            end
            if (flush) begin
                fill <= '0;
            end else if (shift && (fill != FILL_MAX)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Flags when the last SEQ_LEN accepted symbols equal a programmable pattern.
// Detector state (EMPTY / FILLING / FULL) is encoded directly by fill.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter bit OVERLAP = 1'b1,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [SEQ_LEN*DATA_W-1:0]   pattern,
    input  logic                        clear,
    output logic                        match_pulse,
    output logic                        timeout_pulse,
    output logic [fill_w(SEQ_LEN)-1:0]  fill,
    output logic [CNT_W-1:0]            match_count
);

    localparam int FILL_W = fill_w(SEQ_LEN);
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(SEQ_LEN - 1);

    logic [(SEQ_LEN-1)*DATA_W-1:0] window;
    logic [TO_W-1:0]               idle_cnt;
    logic                          accept;
    logic                          match;
    logic                          expire;
    logic                          flush;

    // Input handshake: a symbol is taken on any rising edge with enable=1 and
    // clear=0; there is no back-pressure, so the producer never waits.
    always_comb begin
        accept = enable && !clear;
        match  = accept && (fill >= FILL_PRE) && ({window, data_in} == pattern);
        expire = (TIMEOUT > 0) && !enable && !clear &&
                 (idle_cnt == TO_LAST) && (fill != '0);
        flush  = clear || expire || (match && !OVERLAP);
    end

    sym_window #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN),
        .FILL_W  (FILL_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .shift   (accept),
        .flush   (flush),
        .data_in (data_in),
        .window  (window),
        .fill    (fill)
    );

    // Idle counter parks at TIMEOUT while history is empty so no pulse repeats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (clear || enable) begin
            idle_cnt <= '0;
        end else if (TIMEOUT > 0) begin
            if (expire) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TO_MAX) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_pulse   <= 1'b0;
            timeout_pulse <= 1'b0;
            match_count   <= '0;
        end else begin
            match_pulse   <= match;
            timeout_pulse <= expire;
            if (clear) begin
                match_count <= '0;
            end else if (match && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector across four parameter sets.
module tb_seq_pattern_detector;

    localparam int W = 12;  // {kind, id[1:0], 1'b0, match_count[7:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en   [4];
    logic [3:0]  din  [4];
    logic [15:0] pat  [4];
    logic        clr  [4];
    logic        mp   [4];
    logic        tp   [4];
    logic [2:0]  fill [4];
    logic [7:0]  mc   [3];
    logic [1:0]  mc_sat;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // id0: defaults; id1: non-overlapping; id2: timeout 5; id3: 2-bit counter
    seq_pattern_detector u_ov (
        .clk(clk), .reset(reset), .enable(en[0]), .data_in(din[0]), .pattern(pat[0]),
        .clear(clr[0]), .match_pulse(mp[0]), .timeout_pulse(tp[0]), .fill(fill[0]),
        .match_count(mc[0]));

    seq_pattern_detector #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .enable(en[1]), .data_in(din[1]), .pattern(pat[1]),
        .clear(clr[1]), .match_pulse(mp[1]), .timeout_pulse(tp[1]), .fill(fill[1]),
        .match_count(mc[1]));

    seq_pattern_detector #(.TIMEOUT(5)) u_to (
        .clk(clk), .reset(reset), .enable(en[2]), .data_in(din[2]), .pattern(pat[2]),
        .clear(clr[2]), .match_pulse(mp[2]), .timeout_pulse(tp[2]), .fill(fill[2]),
        .match_count(mc[2]));

    seq_pattern_detector #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .enable(en[3]), .data_in(din[3]), .pattern(pat[3]),
        .clear(clr[3]), .match_pulse(mp[3]), .timeout_pulse(tp[3]), .fill(fill[3]),
        .match_count(mc_sat));

    function automatic logic [7:0] cnt_of(input int id);
        return (id == 3) ? {6'd0, mc_sat} : mc[id];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic score(input logic kind, input int id, input logic [7:0] cnt);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {kind, id[1:0], 1'b0, cnt};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pulse_unexpected actual=%0h required=none", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL pulse_scoreboard actual=%0h required=%0h", got, exp);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (mp[i]) score(1'b0, i, cnt_of(i));
                if (tp[i]) begin
                    score(1'b1, i, cnt_of(i));
                    check("timeout_fill", 32'(fill[i]), 32'd0);
                end
            end
        end
    end

    // Driver tasks: entered and left at posedge+1.
    task automatic strobe(input int id, input logic [3:0] sym, input logic c,
                          input logic exp_m, input logic [7:0] exp_cnt);
        en[id]  = 1'b1;
        din[id] = sym;
        clr[id] = c;
        if (exp_m) exp_q.push_back({1'b0, id[1:0], 1'b0, exp_cnt});
        @(posedge clk);
        #1;
        en[id]  = 1'b0;
        clr[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear(input int id);
        clr[id] = 1'b1;
        @(posedge clk);
        #1;
        clr[id] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b1; din[i] = 4'(i); clr[i] = 1'b0; pat[i] = 16'h1212;
        end
        pat[2] = 16'h8000;

        // Reset held with strobes toggling
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                en[i]  = ~en[i];
                din[i] = din[i] + 4'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check("rst_match_pulse", 32'(mp[i]), 32'd0);
            check("rst_timeout_pulse", 32'(tp[i]), 32'd0);
            check("rst_fill", 32'(fill[i]), 32'd0);
            check("rst_match_count", 32'(cnt_of(i)), 32'd0);
            en[i] = 1'b0;
        end
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) check("post_rst_fill", 32'(fill[i]), 32'd0);

        // Overlapping: 1,2,1,2,1,2 -> matches on 4th and 6th
        strobe(0, 4'h1, 0, 0, 0);
        strobe(0, 4'h2, 0, 0, 0);
        strobe(0, 4'h1, 0, 0, 0);
        check("ov_fill_3", 32'(fill[0]), 32'd3);
        strobe(0, 4'h2, 0, 1, 8'd1);
        check("ov_pulse_4th", 32'(mp[0]), 32'd1);
        strobe(0, 4'h1, 0, 0, 0);
        check("ov_no_pulse_5th", 32'(mp[0]), 32'd0);
        strobe(0, 4'h2, 0, 1, 8'd2);
        check("ov_count", 32'(mc[0]), 32'd2);
        check("ov_fill", 32'(fill[0]), 32'd4);

        // Mismatch and gaps on the same instance, pattern 8,0,0,0
        pat[0] = 16'h8000;
        strobe(0, 4'h8, 0, 0, 0);
        strobe(0, 4'h0, 0, 0, 0);
        strobe(0, 4'h0, 0, 0, 0);
        strobe(0, 4'h1, 0, 0, 0);
        idle(2);
        strobe(0, 4'h8, 0, 0, 0); idle(3);
        strobe(0, 4'h0, 0, 0, 0); idle(3);
        strobe(0, 4'h0, 0, 0, 0); idle(3);
        strobe(0, 4'h0, 0, 1, 8'd3);
        check("gap_count", 32'(mc[0]), 32'd3);

        // Non-overlapping: 1,2,1,2,1,2,1,2 -> matches on 4th and 8th only
        strobe(1, 4'h1, 0, 0, 0);
        strobe(1, 4'h2, 0, 0, 0);
        strobe(1, 4'h1, 0, 0, 0);
        strobe(1, 4'h2, 0, 1, 8'd1);
        check("nov_fill_flushed", 32'(fill[1]), 32'd0);
        strobe(1, 4'h1, 0, 0, 0);
        strobe(1, 4'h2, 0, 0, 0);
        strobe(1, 4'h1, 0, 0, 0);
        strobe(1, 4'h2, 0, 1, 8'd2);
        check("nov_count", 32'(mc[1]), 32'd2);
        check("nov_fill", 32'(fill[1]), 32'd0);

        // Timeout: 8,0 then five idle cycles flush history
        strobe(2, 4'h8, 0, 0, 0);
        strobe(2, 4'h0, 0, 0, 0);
        idle(4);
        check("to_fill_before", 32'(fill[2]), 32'd2);
        check("to_no_early_pulse", 32'(tp[2]), 32'd0);
        exp_q.push_back({1'b1, 2'd2, 1'b0, 8'd0});
        idle(1);
        check("to_pulse", 32'(tp[2]), 32'd1);
        check("to_fill_after", 32'(fill[2]), 32'd0);
        strobe(2, 4'h0, 0, 0, 0);
        strobe(2, 4'h0, 0, 0, 0);
        check("to_refill", 32'(fill[2]), 32'd2);
        check("to_count", 32'(mc[2]), 32'd0);
        do_clear(2);
        check("to_clear_fill", 32'(fill[2]), 32'd0);

        // Saturation with a 2-bit counter, then clear beats the completing strobe
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 0, 0, 0);
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 0, 1, 8'd1);
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 0, 1, 8'd2);
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 0, 1, 8'd3);
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 0, 1, 8'd3);
        check("sat_count", 32'(mc_sat), 32'd3);
        strobe(3, 4'h1, 0, 0, 0);
        strobe(3, 4'h2, 1, 0, 0);
        check("clr_no_pulse", 32'(mp[3]), 32'd0);
        check("clr_count", 32'(mc_sat), 32'd0);
        check("clr_fill", 32'(fill[3]), 32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
